atm_ledger_arbiter: RTL and testbench

Shared account-ledger controller for the ATM subsystem. It arbitrates two ATM front-ends (requester 0, requester 1) that issue balance, deposit and withdraw transactions against a common register-based ledger. It serialises each transaction as a read-modify-write and returns status and the resulting balance over a shared response bus. It sits between the per-terminal ATM session FSMs and the account storage.

---
 rtl/atm_pkg.sv | 25 ++
 rtl/atm_rr_arb2.sv | 37 +++
 rtl/atm_ledger_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared constants for the ATM ledger controller.
//   - Opcodes carried on req_op.
//   - Error codes returned on rsp_err.
//   - FSM state encoding used by atm_ledger_arbiter.
package atm_pkg;

  // Transaction opcodes.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_WDR  = 2'b11;

  // Response error codes.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BAD   = 2'd1;
  localparam logic [1:0] ERR_FUNDS = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  // Controller FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/atm_rr_arb2.sv
// Two-way round-robin picker.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset; last grant starts at requester 1
//   req     in   request vector, one bit per requester
//   update  in   commit the current pick as the new last grant (ignored when req == 0)
//   pick    out  one-hot winner (0 when nothing is requested)
module atm_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] pick
);

  // Index of the requester granted most recently.
  logic last_grant_q;

  always_comb begin
    pick = 2'b00;
    if (req == 2'b11) begin
      // Tie: whoever was not served last goes first.
      pick = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      pick = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (update && (req != 2'b00)) begin
      last_grant_q <= pick[1];
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared account-ledger controller for two ATM front-ends.
// Arbitrates round-robin between two requesters and serialises each transaction as a
// read-modify-write against a register ledger (IDLE -> READ -> EXEC -> RESP).
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset; aborts any transaction in flight
//   req          in   per-requester request, held until ack
//   req_op       in   per-requester opcode (balance / deposit / withdraw / none)
//   req_acct     in   per-requester account index
//   req_amount   in   per-requester amount (ignored for balance)
//   grant        out  one-hot owner of the current transaction
//   busy         out  high whenever the controller is not idle
//   ack          out  one-hot, one-cycle completion pulse
//   rsp_ok       out  transaction succeeded (valid with ack)
//   rsp_err      out  error code (valid with ack)
//   rsp_balance  out  resulting balance, or unchanged balance on error (valid with ack)
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned N_ACCOUNTS   = 4,
  parameter int unsigned AMT_W        = 16,
  parameter int unsigned INIT_BALANCE = 1000,
  localparam int unsigned ACCT_W      = (N_ACCOUNTS > 1) ? $clog2(N_ACCOUNTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req,
  input  logic [1:0][1:0]             req_op,
  input  logic [1:0][ACCT_W-1:0]      req_acct,
  input  logic [1:0][AMT_W-1:0]       req_amount,
  output logic [1:0]                  grant,
  output logic                        busy,
  output logic [1:0]                  ack,
  output logic                        rsp_ok,
  output logic [1:0]                  rsp_err,
  output logic [AMT_W-1:0]            rsp_balance
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q;
  logic [1:0]        op_q;
  logic [ACCT_W-1:0] acct_q;
  logic [AMT_W-1:0]  amt_q;
  logic [AMT_W-1:0]  bal_q;
  logic [1:0]        ack_q;
  logic              rsp_ok_q;
  logic [1:0]        rsp_err_q;
  logic [AMT_W-1:0]  rsp_balance_q;

  logic [AMT_W-1:0]  ledger_q [N_ACCOUNTS];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] pick;
  logic       arb_update;
  logic       win_idx;

  // The last-grant pointer only moves when a transaction is actually accepted.
  assign arb_update = (state_q == ST_IDLE);
  assign win_idx    = pick[1];

  atm_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (arb_update),
    .pick   (pick)
  );

  // ---------------------------------------------------------------------------
  // Ledger read port and account range check
  // ---------------------------------------------------------------------------
  logic             acct_ok;
  logic [AMT_W-1:0] rd_bal;

  // Indices beyond N_ACCOUNTS are representable when N_ACCOUNTS is not a power of two.
  assign acct_ok = (32'(acct_q) < N_ACCOUNTS);

  always_comb begin
    rd_bal = '0;
    for (int unsigned i = 0; i < N_ACCOUNTS; i++) begin
      if (ACCT_W'(i) == acct_q) begin
        rd_bal = ledger_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Execute: evaluate the latched op against the fetched balance
  // ---------------------------------------------------------------------------
  logic [AMT_W:0]   sum;
  logic             ex_ok;
  logic [1:0]       ex_err;
  logic [AMT_W-1:0] ex_bal;
  logic             ex_we;

  always_comb begin
    // One extra bit so a deposit overflow shows up as the carry.
    sum    = {1'b0, bal_q} + {1'b0, amt_q};
    ex_ok  = 1'b0;
    ex_err = ERR_NONE;
    ex_bal = bal_q;
    ex_we  = 1'b0;
    if ((op_q == OP_NONE) || !acct_ok) begin
      ex_err = ERR_BAD;
    end else begin
      unique case (op_q)
        OP_BAL: begin
          ex_ok = 1'b1;
        end
        OP_DEP: begin
          if (sum[AMT_W]) begin
            ex_err = ERR_OVF;
          end else begin
            ex_ok  = 1'b1;
            ex_bal = sum[AMT_W-1:0];
            ex_we  = 1'b1;
          end
        end
        OP_WDR: begin
          if (amt_q > bal_q) begin
            ex_err = ERR_FUNDS;
          end else begin
            ex_ok  = 1'b1;
            ex_bal = bal_q - amt_q;
            ex_we  = 1'b1;
          end
        end
        default: begin
          ex_err = ERR_BAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req != 2'b00) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      op_q          <= OP_NONE;
      acct_q        <= '0;
      amt_q         <= '0;
      bal_q         <= '0;
      ack_q         <= '0;
      rsp_ok_q      <= 1'b0;
      rsp_err_q     <= ERR_NONE;
      rsp_balance_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          // Request fields are captured only here; later changes are ignored.
          if (req != 2'b00) begin
            grant_q <= pick;
            op_q    <= req_op[win_idx];
            acct_q  <= req_acct[win_idx];
            amt_q   <= req_amount[win_idx];
          end
        end
        ST_READ: begin
          bal_q <= acct_ok ? rd_bal : '0;
        end
        ST_EXEC: begin
          ack_q         <= grant_q;
          rsp_ok_q      <= ex_ok;
          rsp_err_q     <= ex_err;
          rsp_balance_q <= ex_bal;
        end
        ST_RESP: begin
          grant_q       <= '0;
          ack_q         <= '0;
          rsp_ok_q      <= 1'b0;
          rsp_err_q     <= ERR_NONE;
          rsp_balance_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Ledger storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_ACCOUNTS; i++) begin
        ledger_q[i] <= AMT_W'(INIT_BALANCE);
      end
    end else if ((state_q == ST_EXEC) && ex_we) begin
      for (int unsigned i = 0; i < N_ACCOUNTS; i++) begin
        if (ACCT_W'(i) == acct_q) begin
          ledger_q[i] <= ex_bal;
        end
      end
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign ack         = ack_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Bench for atm_ledger_arbiter. Two instances (4 and 3 accounts) see identical stimulus;
// each is compared against a transaction-level ledger model.
module tb_atm_ledger_arbiter;

  localparam int AMT_W = 16;
  localparam int MAX_BAL = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]            req;
  logic [1:0][1:0]       req_op;
  logic [1:0][1:0]       req_acct;
  logic [1:0][AMT_W-1:0] req_amount;

  logic [1:0]       grant_w     [2];
  logic             busy_w      [2];
  logic [1:0]       ack_w       [2];
  logic             rsp_ok_w    [2];
  logic [1:0]       rsp_err_w   [2];
  logic [AMT_W-1:0] rsp_bal_w   [2];

  atm_ledger_arbiter #(
    .N_ACCOUNTS   (4),
    .AMT_W        (AMT_W),
    .INIT_BALANCE (1000)
  ) dut4 (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (req_op),
    .req_acct    (req_acct),
    .req_amount  (req_amount),
    .grant       (grant_w[0]),
    .busy        (busy_w[0]),
    .ack         (ack_w[0]),
    .rsp_ok      (rsp_ok_w[0]),
    .rsp_err     (rsp_err_w[0]),
    .rsp_balance (rsp_bal_w[0])
  );

  atm_ledger_arbiter #(
    .N_ACCOUNTS   (3),
    .AMT_W        (AMT_W),
    .INIT_BALANCE (1000)
  ) dut3 (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (req_op),
    .req_acct    (req_acct),
    .req_amount  (req_amount),
    .grant       (grant_w[1]),
    .busy        (busy_w[1]),
    .ack         (ack_w[1]),
    .rsp_ok      (rsp_ok_w[1]),
    .rsp_err     (rsp_err_w[1]),
    .rsp_balance (rsp_bal_w[1])
  );

  int tests_run;
  int tests_failed;

  // Reference model state: per-instance ledger and the round-robin pointer.
  int ledger_m [2][4];
  int n_m [2] = '{4, 3};
  int last_m;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) ledger_m[i][j] = 1000;
    end
    last_m = 1;
  endfunction

  function automatic void model_exec(input int inst, input int op, input int acct, input int amt,
                                     output int ok, output int err, output int bal);
    int cur;
    ok  = 0;
    err = 0;
    cur = (acct < n_m[inst]) ? ledger_m[inst][acct] : 0;
    bal = cur;
    if (op == 0 || acct >= n_m[inst]) begin
      err = 1;
    end else if (op == 1) begin
      ok = 1;
    end else if (op == 2) begin
      if (cur + amt > MAX_BAL) err = 3;
      else begin
        ok = 1;
        bal = cur + amt;
        ledger_m[inst][acct] = bal;
      end
    end else begin
      if (amt > cur) err = 2;
      else begin
        ok = 1;
        bal = cur - amt;
        ledger_m[inst][acct] = bal;
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues one request (v = 01/10) or a simultaneous pair (v = 11) and checks every cycle
  // until the controller is idle again. abort_at > 0 asserts reset after that many cycles.
  task automatic run_txn(input logic [1:0] v,
                         input int op0, input int a0, input int m0,
                         input int op1, input int a1, input int m1,
                         input bit scramble, input int abort_at);
    int ops [2];
    int accts [2];
    int amts [2];
    int first, second, nk, slot;
    int ok_e [2][2];
    int err_e [2][2];
    int bal_e [2][2];
    logic [1:0] exp_ack, exp_grant;
    string sfx;

    ops   = '{op0, op1};
    accts = '{a0, a1};
    amts  = '{m0, m1};
    if (v == 2'b11) begin
      first  = (last_m == 1) ? 0 : 1;
      second = 1 - first;
    end else begin
      first  = v[1] ? 1 : 0;
      second = -1;
    end
    nk = (second >= 0) ? 8 : 4;

    if (abort_at == 0) begin
      for (int i = 0; i < 2; i++) begin
        model_exec(i, ops[first], accts[first], amts[first],
                   ok_e[i][0], err_e[i][0], bal_e[i][0]);
        if (second >= 0) begin
          model_exec(i, ops[second], accts[second], amts[second],
                     ok_e[i][1], err_e[i][1], bal_e[i][1]);
        end
      end
      last_m = (second >= 0) ? second : first;
    end

    for (int r = 0; r < 2; r++) begin
      req_op[r]     = 2'(ops[r]);
      req_acct[r]   = 2'(accts[r]);
      req_amount[r] = 16'(amts[r]);
    end
    req = v;

    for (int k = 1; k <= nk; k++) begin
      @(negedge clk);
      exp_ack   = 2'b00;
      exp_grant = 2'b00;
      if (k >= 1 && k <= 3) exp_grant = 2'(1 << first);
      if (k >= 5 && k <= 7) exp_grant = 2'(1 << second);
      if (k == 3) exp_ack = 2'(1 << first);
      if (k == 7) exp_ack = 2'(1 << second);
      slot = (k == 3) ? 0 : ((k == 7) ? 1 : -1);
      for (int i = 0; i < 2; i++) begin
        sfx = $sformatf("[n%0d k%0d]", n_m[i], k);
        check({"grant", sfx}, int'(grant_w[i]), int'(exp_grant));
        check({"busy", sfx}, int'(busy_w[i]), ((k % 4) != 0) ? 1 : 0);
        check({"ack", sfx}, int'(ack_w[i]), int'(exp_ack));
        if (slot >= 0) begin
          check({"rsp_ok", sfx}, int'(rsp_ok_w[i]), ok_e[i][slot]);
          check({"rsp_err", sfx}, int'(rsp_err_w[i]), err_e[i][slot]);
          check({"rsp_balance", sfx}, int'(rsp_bal_w[i]), bal_e[i][slot]);
        end else begin
          check({"rsp_ok_idle", sfx}, int'(rsp_ok_w[i]), 0);
          check({"rsp_bal_idle", sfx}, int'(rsp_bal_w[i]), 0);
        end
      end

      if (abort_at != 0 && k == abort_at) begin
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          sfx = $sformatf("[n%0d abort]", n_m[i]);
          check({"grant", sfx}, int'(grant_w[i]), 0);
          check({"busy", sfx}, int'(busy_w[i]), 0);
          check({"ack", sfx}, int'(ack_w[i]), 0);
          check({"rsp_ok", sfx}, int'(rsp_ok_w[i]), 0);
          check({"rsp_balance", sfx}, int'(rsp_bal_w[i]), 0);
        end
        reset = 1'b0;
        model_reset();
        return;
      end

      // Post-grant changes to the winner's fields (or dropping its req) must not matter.
      if (k == 1 && scramble) begin
        req_op[first]     = 2'($urandom);
        req_acct[first]   = 2'($urandom);
        req_amount[first] = 16'($urandom);
        if ($urandom_range(0, 1) == 1) req[first] = 1'b0;
      end
      if (k == 3) req[first] = 1'b0;
      if (k == 7) req[second] = 1'b0;
    end
  endtask

  initial begin
    int v, o0, o1, c0, c1, m0, m1;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    req          = 2'b00;
    req_op       = '0;
    req_acct     = '0;
    req_amount   = '0;
    model_reset();

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_grant", int'(grant_w[i]), 0);
      check("reset_busy", int'(busy_w[i]), 0);
      check("reset_ack", int'(ack_w[i]), 0);
      check("reset_ok", int'(rsp_ok_w[i]), 0);
      check("reset_err", int'(rsp_err_w[i]), 0);
      check("reset_balance", int'(rsp_bal_w[i]), 0);
    end
    reset = 1'b0;

    // Withdraw 64 from acct0 -> 936.
    run_txn(2'b01, 3, 0, 64, 0, 0, 0, 1'b0, 0);
    // Insufficient funds on acct1.
    run_txn(2'b10, 0, 0, 0, 3, 1, 2000, 1'b0, 0);
    run_txn(2'b10, 0, 0, 0, 1, 1, 0, 1'b0, 0);
    // Tie after reset: requester 0 deposit then requester 1 balance, both 1064.
    do_reset();
    run_txn(2'b11, 2, 2, 64, 1, 2, 0, 1'b0, 0);
    // Overflow on acct3, then withdraw exactly the balance.
    run_txn(2'b01, 2, 3, 65000, 0, 0, 0, 1'b0, 0);
    run_txn(2'b10, 0, 0, 0, 3, 3, 1000, 1'b0, 0);
    // Invalid opcode leaves acct0 alone.
    run_txn(2'b01, 0, 0, 500, 0, 0, 0, 1'b0, 0);
    run_txn(2'b01, 1, 0, 0, 0, 0, 0, 1'b0, 0);
    // Reset during EXEC aborts a deposit.
    run_txn(2'b01, 2, 1, 500, 0, 0, 0, 1'b0, 2);
    run_txn(2'b01, 1, 1, 0, 0, 0, 0, 1'b0, 0);
    // Second tie alternates the winner.
    run_txn(2'b11, 3, 0, 10, 3, 0, 20, 1'b0, 0);
    run_txn(2'b11, 1, 0, 0, 1, 1, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      v  = $urandom_range(1, 3);
      o0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      o1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      m0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_BAL) : $urandom_range(0, 1200);
      m1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_BAL) : $urandom_range(0, 1200);
      run_txn(2'(v), o0, c0, m0, o1, c1, m1, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
